multi_alarm_ctrl: RTL and testbench
===================================

// Module: multi_alarm_ctrl
// PURPOSE
//  N-slot alarm controller with snooze limit, for the next-generation clock datapath.
//  Stores NUM_ALARMS programmable HH:MM alarms and compares them against the running BCD time.
//  Drives the ring/snooze state machine: ring, snooze countdown, re-ring, dismiss.
//  Replaces the single-alarm compare and the fixed 30 s snooze counter in the top level.
// PARAMETERS
//  NUM_ALARMS   4    number of alarm slots (1..8)
//  SNOOZE_SECS  300  snooze length in sec_tick periods (>=1)
//  MAX_SNOOZE   3    snoozes allowed per ring event; further snooze requests are ignored
//  RING_TIMEOUT 60   seconds of ringing before auto-action (used only with ALARM_TIMEOUT_EN)
// PORTS
//  clk          in   1   single system clock
//  rst          in   1   asynchronous reset, active-low
//  sec_tick     in   1   one-clk pulse per second, from the timebase
//  cur_h1       in   2   current hour tens (BCD)
//  cur_h2       in   4   current hour units (BCD)
//  cur_m1       in   3   current minute tens (BCD)
//  cur_m2       in   4   current minute units (BCD)
//  cur_s        in   6   current seconds, binary 0..59
//  wr_en        in   1   write one alarm slot this cycle
//  wr_sel       in   IW  slot index, IW = $clog2(NUM_ALARMS), minimum 1
//  wr_h1/h2/m1/m2 in 2/4/3/4  new alarm time (BCD)
//  wr_arm       in   1   armed bit written with the slot
//  snooze       in   1   one-clk pulse (debounced button)
//  dismiss      in   1   one-clk pulse
//  ring         out  1   alarm sounding
//  snoozing     out  1   snooze countdown active
//  active_id    out  IW  slot that triggered the current event
//  snooze_left  out  SW  remaining snooze seconds, SW = $clog2(SNOOZE_SECS+1)
//  snooze_cnt   out  2+  snoozes used in the current event, width $clog2(MAX_SNOOZE+1)
//  armed        out  N   per-slot armed bits
//  wr_err       out  1   one-clk pulse: write rejected
// BEHAVIOUR
//  Reset (rst=0, async): all slots 00:00 and disarmed; state IDLE; every output 0.
//  FSM states: IDLE, RINGING, SNOOZING. All outputs are registered.
//  Trigger: in IDLE, sec_tick=1 with cur_s==0 and an armed slot matching cur HH:MM -> RINGING next cycle.
//   The lowest matching index wins and is latched into active_id; snooze_cnt is cleared.
//   Matches while RINGING/SNOOZING are dropped; nothing is queued.
//   The cur_s==0 qualifier gives exactly one trigger per minute, so a dismiss within the minute does not re-ring.
//  RINGING: ring=1.
//   dismiss -> IDLE, snooze_cnt cleared.
//   snooze with snooze_cnt<MAX_SNOOZE -> SNOOZING; snooze_left=SNOOZE_SECS; snooze_cnt+1.
//   snooze with snooze_cnt==MAX_SNOOZE -> ignored; stays RINGING.
//  SNOOZING: ring=0, snoozing=1. Each sec_tick decrements snooze_left.
//   A tick taken at snooze_left==1 -> RINGING with snooze_left=0.
//   dismiss -> IDLE; snooze ignored.
//  dismiss and snooze in the same cycle: dismiss wins.
//  Writes: accepted any cycle and take effect next cycle.
//   Reject when h1>2, h2>9, (h1==2 && h2>3), m1>5, m2>9, or wr_sel>=NUM_ALARMS.
//   A rejected write leaves the slot unchanged and pulses wr_err.
//   Writing wr_arm=0 to active_id while RINGING/SNOOZING -> IDLE next cycle. Any other write leaves the FSM unchanged.
//  A write and a trigger in the same cycle: the compare uses the pre-write slot contents.
// CONFIGURATION
//  ALARM_TIMEOUT_EN defined: in RINGING, count sec_ticks. At RING_TIMEOUT ticks the block auto-snoozes.
//   The auto-snooze follows the same rules as a snooze press and counts against MAX_SNOOZE.
//   If no snoozes remain, the timeout goes to IDLE.
//  ALARM_TIMEOUT_EN undefined: no timeout counter is built; RINGING persists until dismiss/snooze/disarm.
// STRUCTURE
//  Package alarm_pkg: state enum (IDLE/RINGING/SNOOZING), bcd_time_t struct {h1,h2,m1,m2}.
//   It also holds the BCD range-check function and the limit constants (2,3,5,9).
//  Sub-module alarm_slot: one slot's storage, armed bit and equality compare.
//   Instantiated NUM_ALARMS times in a generate loop.
//  Top level: priority encoder, FSM, snooze down-counter, optional timeout counter.
// TESTING
//  Program slot2=07:30 armed; time 07:29:59 -> 07:30:00 tick -> ring=1 next cycle, active_id=2.
//  Slots 1 and 3 both 06:00 armed -> trigger gives active_id=1.
//   A dismiss at 06:00:10 gives no re-ring during 06:00.
//  SNOOZE_SECS=5: ring, snooze -> snoozing=1, snooze_left 5..1.
//   The 5th tick gives ring=1 and snooze_cnt=1.
//  MAX_SNOOZE=2: after 2 snoozes a third snooze keeps ring=1 and snooze_cnt=2.
//   Same-cycle snooze+dismiss -> IDLE.
//  Write 24:00 to slot0 -> wr_err pulse, slot unchanged. Write wr_arm=0 to the active slot while ringing -> IDLE.
//  rst low mid-SNOOZING -> ring, snoozing, snooze_left, armed are 0 asynchronously.
//   With ALARM_TIMEOUT_EN and RING_TIMEOUT=3: 3 ticks of ringing -> SNOOZING.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and BCD limits for the multi-slot alarm controller.
// Holds the FSM state enum, the HH:MM BCD time struct and the time range check.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RINGING  = 2'd1,
    SNOOZING = 2'd2
  } alarm_state_e;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h2;
    logic [2:0] m1;
    logic [3:0] m2;
  } bcd_time_t;

  localparam logic [1:0] H1_MAX     = 2'd2;
  localparam logic [3:0] H2_MAX     = 4'd9;
  localparam logic [3:0] H2_MAX_20S = 4'd3;
  localparam logic [2:0] M1_MAX     = 3'd5;
  localparam logic [3:0] M2_MAX     = 4'd9;

  // True when t is a legal 24-hour HH:MM value (00:00 .. 23:59).
  function automatic logic bcd_time_ok(input bcd_time_t t);
    return !((t.h1 > H1_MAX) || (t.h2 > H2_MAX) ||
             ((t.h1 == H1_MAX) && (t.h2 > H2_MAX_20S)) ||
             (t.m1 > M1_MAX) || (t.m2 > M2_MAX));
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: stored HH:MM, armed bit, and equality compare against the
// current time. The compare sees the pre-write contents on a write cycle.
module alarm_slot
  import alarm_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wr_en,
  input  bcd_time_t wr_time,
  input  logic      wr_arm,
  input  bcd_time_t cur_time,
  output logic      match,
  output logic      armed
);

  bcd_time_t time_q, time_d;
  logic      armed_q, armed_d;

  // Next-state for the slot storage.
  always_comb begin
    time_d  = time_q;
    armed_d = armed_q;
    if (wr_en) begin
      time_d  = wr_time;
      armed_d = wr_arm;
    end else begin
      time_d  = time_q;
      armed_d = armed_q;
    end
  end

  // Slot storage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      time_q  <= time_d;
      armed_q <= armed_d;
    end
  end

  assign match = armed_q && (time_q == cur_time);
  assign armed = armed_q;

endmodule

// File: rtl/multi_alarm_ctrl.sv
// N-slot alarm controller: slot array, lowest-index priority select, ring/snooze FSM
// with a bounded snooze count. Optional ring timeout enabled by `define ALARM_TIMEOUT_EN.
module multi_alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS   = 4,
  parameter int SNOOZE_SECS  = 300,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 60,
  localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int SW = $clog2(SNOOZE_SECS + 1),
  localparam int CW = ($clog2(MAX_SNOOZE + 1) < 2) ? 2 : $clog2(MAX_SNOOZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sec_tick,
  input  logic [1:0]            cur_h1,
  input  logic [3:0]            cur_h2,
  input  logic [2:0]            cur_m1,
  input  logic [3:0]            cur_m2,
  input  logic [5:0]            cur_s,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_sel,
  input  logic [1:0]            wr_h1,
  input  logic [3:0]            wr_h2,
  input  logic [2:0]            wr_m1,
  input  logic [3:0]            wr_m2,
  input  logic                  wr_arm,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic                  ring,
  output logic                  snoozing,
  output logic [IW-1:0]         active_id,
  output logic [SW-1:0]         snooze_left,
  output logic [CW-1:0]         snooze_cnt,
  output logic [NUM_ALARMS-1:0] armed,
  output logic                  wr_err
);

  if ((NUM_ALARMS < 1) || (NUM_ALARMS > 8) || (SNOOZE_SECS < 1) || (RING_TIMEOUT < 1)) begin : g_bad_params
    $error("multi_alarm_ctrl: parameter out of range");
  end

  bcd_time_t cur_time_s, wr_time_s;
  logic      wr_ok_s;
  assign cur_time_s = '{h1: cur_h1, h2: cur_h2, m1: cur_m1, m2: cur_m2};
  assign wr_time_s  = '{h1: wr_h1, h2: wr_h2, m1: wr_m1, m2: wr_m2};
  assign wr_ok_s    = bcd_time_ok(wr_time_s) && (32'(wr_sel) < NUM_ALARMS);

  logic [NUM_ALARMS-1:0] match_s, slot_we_s;

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
    assign slot_we_s[g] = wr_en && wr_ok_s && (wr_sel == IW'(g));
    alarm_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (slot_we_s[g]),
      .wr_time  (wr_time_s),
      .wr_arm   (wr_arm),
      .cur_time (cur_time_s),
      .match    (match_s[g]),
      .armed    (armed[g])
    );
  end

  logic [IW-1:0] hit_id_s;

  // Lowest matching slot index wins.
  always_comb begin
    hit_id_s = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (match_s[i]) hit_id_s = IW'(i);
      else            hit_id_s = hit_id_s;
    end
  end

  alarm_state_e  state_q, state_d;
  logic [IW-1:0] active_id_q, active_id_d;
  logic [SW-1:0] snooze_left_q, snooze_left_d;
  logic [CW-1:0] snooze_cnt_q, snooze_cnt_d;
  logic          ring_q, ring_d, snoozing_q, snoozing_d, wr_err_q, wr_err_d;
  logic          trigger_s, can_snooze_s, disarm_active_s;

  assign trigger_s       = sec_tick && (cur_s == 6'd0) && (|match_s);
  assign can_snooze_s    = (snooze_cnt_q < CW'(MAX_SNOOZE));
  assign disarm_active_s = wr_en && wr_ok_s && !wr_arm && (wr_sel == active_id_q);

`ifdef ALARM_TIMEOUT_EN
  localparam int TW = $clog2(RING_TIMEOUT + 1);
  logic [TW-1:0] ring_tmo_q, ring_tmo_d;
  logic          timeout_s;
`endif

  // Ring/snooze FSM next-state; dismiss beats snooze, disarm of the active slot beats both.
  always_comb begin
    state_d       = state_q;
    active_id_d   = active_id_q;
    snooze_left_d = snooze_left_q;
    snooze_cnt_d  = snooze_cnt_q;
`ifdef ALARM_TIMEOUT_EN
    ring_tmo_d    = '0;
    timeout_s     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (trigger_s) begin
          state_d      = RINGING;
          active_id_d  = hit_id_s;
          snooze_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RINGING: begin
`ifdef ALARM_TIMEOUT_EN
        if (sec_tick) begin
          if (ring_tmo_q == TW'(RING_TIMEOUT - 1)) timeout_s = 1'b1;
          else                                     ring_tmo_d = ring_tmo_q + TW'(1);
        end else begin
          ring_tmo_d = ring_tmo_q;
        end
`endif
        if (dismiss) begin
          state_d      = IDLE;
          snooze_cnt_d = '0;
        end else if (snooze && can_snooze_s) begin
          state_d       = SNOOZING;
          snooze_left_d = SW'(SNOOZE_SECS);
          snooze_cnt_d  = snooze_cnt_q + CW'(1);
`ifdef ALARM_TIMEOUT_EN
        end else if (timeout_s) begin
          // Auto-snooze consumes a snooze; with none left the event ends.
          if (can_snooze_s) begin
            state_d       = SNOOZING;
            snooze_left_d = SW'(SNOOZE_SECS);
            snooze_cnt_d  = snooze_cnt_q + CW'(1);
          end else begin
            state_d      = IDLE;
            snooze_cnt_d = '0;
          end
`endif
        end else begin
          state_d = RINGING;
        end
      end
      SNOOZING: begin
        if (dismiss) begin
          state_d       = IDLE;
          snooze_left_d = '0;
          snooze_cnt_d  = '0;
        end else if (sec_tick) begin
          if (snooze_left_q == SW'(1)) begin
            state_d       = RINGING;
            snooze_left_d = '0;
          end else begin
            snooze_left_d = snooze_left_q - SW'(1);
          end
        end else begin
          state_d = SNOOZING;
        end
      end
      default: begin
        state_d       = IDLE;
        snooze_left_d = '0;
        snooze_cnt_d  = '0;
      end
    endcase
    if ((state_q != IDLE) && disarm_active_s) begin
      state_d       = IDLE;
      snooze_left_d = '0;
      snooze_cnt_d  = '0;
    end else begin
      state_d = state_d;
    end
    ring_d     = (state_d == RINGING);
    snoozing_d = (state_d == SNOOZING);
    wr_err_d   = wr_en && !wr_ok_s;
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      active_id_q   <= '0;
      snooze_left_q <= '0;
      snooze_cnt_q  <= '0;
      ring_q        <= 1'b0;
      snoozing_q    <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_id_q   <= active_id_d;
      snooze_left_q <= snooze_left_d;
      snooze_cnt_q  <= snooze_cnt_d;
      ring_q        <= ring_d;
      snoozing_q    <= snoozing_d;
      wr_err_q      <= wr_err_d;
    end
  end

`ifdef ALARM_TIMEOUT_EN
  // Ring timeout counter, cleared whenever not ringing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ring_tmo_q <= '0;
    else      ring_tmo_q <= ring_tmo_d;
  end
`endif

  assign ring        = ring_q;
  assign snoozing    = snoozing_q;
  assign active_id   = active_id_q;
  assign snooze_left = snooze_left_q;
  assign snooze_cnt  = snooze_cnt_q;
  assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl (4 slots, 5 s snooze, 2 snoozes max, 3 s timeout).
module tb_multi_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst, sec_tick, wr_en, wr_arm, snooze, dismiss;
  logic [1:0] cur_h1, wr_h1, wr_sel;
  logic [3:0] cur_h2, cur_m2, wr_h2, wr_m2;
  logic [2:0] cur_m1, wr_m1;
  logic [5:0] cur_s;
  logic       ring, snoozing, wr_err;
  logic [1:0] active_id, snooze_cnt;
  logic [2:0] snooze_left;
  logic [3:0] armed;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_alarm_ctrl #(.NUM_ALARMS(4), .SNOOZE_SECS(5), .MAX_SNOOZE(2), .RING_TIMEOUT(3)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick),
    .cur_h1(cur_h1), .cur_h2(cur_h2), .cur_m1(cur_m1), .cur_m2(cur_m2), .cur_s(cur_s),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_h1(wr_h1), .wr_h2(wr_h2), .wr_m1(wr_m1), .wr_m2(wr_m2),
    .wr_arm(wr_arm), .snooze(snooze), .dismiss(dismiss),
    .ring(ring), .snoozing(snoozing), .active_id(active_id), .snooze_left(snooze_left),
    .snooze_cnt(snooze_cnt), .armed(armed), .wr_err(wr_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [1:0] h1, input logic [3:0] h2, input logic [2:0] m1,
                      input logic [3:0] m2, input logic [5:0] s);
    cur_h1 = h1; cur_h2 = h2; cur_m1 = m1; cur_m2 = m2; cur_s = s;
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [1:0] h1, input logic [3:0] h2,
                    input logic [2:0] m1, input logic [3:0] m2, input logic arm);
    wr_sel = sel; wr_h1 = h1; wr_h2 = h2; wr_m1 = m1; wr_m2 = m2; wr_arm = arm;
    wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic press_snooze();
    snooze = 1'b1; cyc(); snooze = 1'b0;
  endtask

  task automatic press_dismiss();
    dismiss = 1'b1; cyc(); dismiss = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (ring !== 1'b0) begin n_err++; $display("FAIL rst_ring: got %0b want 0", ring); end
    n_vec++; if (snoozing !== 1'b0) begin n_err++; $display("FAIL rst_snoozing: got %0b want 0", snoozing); end
    n_vec++; if (active_id !== 2'd0) begin n_err++; $display("FAIL rst_active_id: got %0d want 0", active_id); end
    n_vec++; if (snooze_left !== 3'd0) begin n_err++; $display("FAIL rst_snooze_left: got %0d want 0", snooze_left); end
    n_vec++; if (snooze_cnt !== 2'd0) begin n_err++; $display("FAIL rst_snooze_cnt: got %0d want 0", snooze_cnt); end
    n_vec++; if (armed !== 4'b0000) begin n_err++; $display("FAIL rst_armed: got %b want 0000", armed); end
    n_vec++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL rst_wr_err: got %0b want 0", wr_err); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_trigger();
    wr(2'd2, 2'd0, 4'd7, 3'd3, 4'd0, 1'b1);
    n_vec++; if (armed !== 4'b0100) begin n_err++; $display("FAIL trig_armed: got %b want 0100", armed); end
    tick(2'd0, 4'd7, 3'd2, 4'd9, 6'd59);
    n_vec++; if (ring !== 1'b0) begin n_err++; $display("FAIL trig_early: got %0b want 0", ring); end
    tick(2'd0, 4'd7, 3'd3, 4'd0, 6'd0);
    n_vec++; if (ring !== 1'b1) begin n_err++; $display("FAIL trig_ring: got %0b want 1", ring); end
    n_vec++; if (active_id !== 2'd2) begin n_err++; $display("FAIL trig_id: got %0d want 2", active_id); end
    n_vec++; if (snooze_cnt !== 2'd0) begin n_err++; $display("FAIL trig_cnt: got %0d want 0", snooze_cnt); end
    press_dismiss();
    n_vec++; if (ring !== 1'b0) begin n_err++; $display("FAIL trig_dismiss: got %0b want 0", ring); end
    wr(2'd2, 2'd0, 4'd7, 3'd3, 4'd0, 1'b0);
    n_vec++; if (armed !== 4'b0000) begin n_err++; $display("FAIL trig_disarm: got %b want 0000", armed); end
  endtask

  task automatic test_priority();
    wr(2'd1, 2'd0, 4'd6, 3'd0, 4'd0, 1'b1);
    wr(2'd3, 2'd0, 4'd6, 3'd0, 4'd0, 1'b1);
    n_vec++; if (armed !== 4'b1010) begin n_err++; $display("FAIL prio_armed: got %b want 1010", armed); end
    tick(2'd0, 4'd6, 3'd0, 4'd0, 6'd0);
    n_vec++; if (ring !== 1'b1) begin n_err++; $display("FAIL prio_ring: got %0b want 1", ring); end
    n_vec++; if (active_id !== 2'd1) begin n_err++; $display("FAIL prio_id: got %0d want 1", active_id); end
    for (int s = 1; s < 10; s++) tick(2'd0, 4'd6, 3'd0, 4'd0, 6'(s));
    press_dismiss();
    n_vec++; if (ring !== 1'b0) begin n_err++; $display("FAIL prio_dismiss: got %0b want 0", ring); end
    for (int s = 10; s < 60; s++) begin
      tick(2'd0, 4'd6, 3'd0, 4'd0, 6'(s));
      n_vec++; if (ring !== 1'b0) begin n_err++; $display("FAIL prio_rering s=%0d: got %0b want 0", s, ring); end
    end
    tick(2'd0, 4'd6, 3'd0, 4'd1, 6'd0);
    n_vec++; if (ring !== 1'b0) begin n_err++; $display("FAIL prio_nomatch: got %0b want 0", ring); end
  endtask

  task automatic test_snooze();
    tick(2'd0, 4'd6, 3'd0, 4'd0, 6'd0);
    n_vec++; if (ring !== 1'b1) begin n_err++; $display("FAIL snz_ring: got %0b want 1", ring); end
    press_snooze();
    n_vec++; if (ring !== 1'b0) begin n_err++; $display("FAIL snz_ring_off: got %0b want 0", ring); end
    n_vec++; if (snoozing !== 1'b1) begin n_err++; $display("FAIL snz_snoozing: got %0b want 1", snoozing); end
    n_vec++; if (snooze_left !== 3'd5) begin n_err++; $display("FAIL snz_left_init: got %0d want 5", snooze_left); end
    n_vec++; if (snooze_cnt !== 2'd1) begin n_err++; $display("FAIL snz_cnt: got %0d want 1", snooze_cnt); end
    for (int k = 4; k >= 1; k--) begin
      tick(2'd0, 4'd6, 3'd0, 4'd1, 6'd1);
      n_vec++; if (snooze_left !== 3'(k)) begin n_err++; $display("FAIL snz_left: got %0d want %0d", snooze_left, k); end
    end
    tick(2'd0, 4'd6, 3'd0, 4'd1, 6'd1);
    n_vec++; if (ring !== 1'b1) begin n_err++; $display("FAIL snz_rering: got %0b want 1", ring); end
    n_vec++; if (snoozing !== 1'b0) begin n_err++; $display("FAIL snz_end: got %0b want 0", snoozing); end
    n_vec++; if (snooze_left !== 3'd0) begin n_err++; $display("FAIL snz_left_end: got %0d want 0", snooze_left); end
    n_vec++; if (snooze_cnt !== 2'd1) begin n_err++; $display("FAIL snz_cnt_end: got %0d want 1", snooze_cnt); end
  endtask

  task automatic test_max_snooze();
    press_snooze();
    n_vec++; if (snooze_cnt !== 2'd2) begin n_err++; $display("FAIL max_cnt2: got %0d want 2", snooze_cnt); end
    press_snooze();
    n_vec++; if (snooze_left !== 3'd5) begin n_err++; $display("FAIL max_snz_in_snooze: got %0d want 5", snooze_left); end
    n_vec++; if (snoozing !== 1'b1) begin n_err++; $display("FAIL max_still_snoozing: got %0b want 1", snoozing); end
    for (int k = 0; k < 5; k++) tick(2'd0, 4'd6, 3'd0, 4'd2, 6'd1);
    n_vec++; if (ring !== 1'b1) begin n_err++; $display("FAIL max_rering: got %0b want 1", ring); end
    press_snooze();
    n_vec++; if (ring !== 1'b1) begin n_err++; $display("FAIL max_third_ring: got %0b want 1", ring); end
    n_vec++; if (snoozing !== 1'b0) begin n_err++; $display("FAIL max_third_snoozing: got %0b want 0", snoozing); end
    n_vec++; if (snooze_cnt !== 2'd2) begin n_err++; $display("FAIL max_third_cnt: got %0d want 2", snooze_cnt); end
    snooze = 1'b1; dismiss = 1'b1; cyc(); snooze = 1'b0; dismiss = 1'b0;
    n_vec++; if (ring !== 1'b0) begin n_err++; $display("FAIL max_both_ring: got %0b want 0", ring); end
    n_vec++; if (snooze_cnt !== 2'd0) begin n_err++; $display("FAIL max_both_cnt: got %0d want 0", snooze_cnt); end
  endtask

  task automatic test_back_to_back();
    tick(2'd0, 4'd6, 3'd0, 4'd0, 6'd0);
    snooze = 1'b1; dismiss = 1'b1; cyc(); snooze = 1'b0; dismiss = 1'b0;
    n_vec++; if (ring !== 1'b0) begin n_err++; $display("FAIL b2b_ring: got %0b want 0", ring); end
    n_vec++; if (snoozing !== 1'b0) begin n_err++; $display("FAIL b2b_snoozing: got %0b want 0", snoozing); end
    tick(2'd0, 4'd6, 3'd0, 4'd0, 6'd0);
    press_snooze();
    tick(2'd0, 4'd6, 3'd0, 4'd0, 6'd0);
    n_vec++; if (snooze_left !== 3'd4) begin n_err++; $display("FAIL b2b_drop_left: got %0d want 4", snooze_left); end
    n_vec++; if (ring !== 1'b0) begin n_err++; $display("FAIL b2b_drop_ring: got %0b want 0", ring); end
    press_dismiss();
    n_vec++; if (snoozing !== 1'b0) begin n_err++; $display("FAIL b2b_dismiss_snz: got %0b want 0", snoozing); end
    n_vec++; if (ring !== 1'b0) begin n_err++; $display("FAIL b2b_dismiss_ring: got %0b want 0", ring); end
  endtask

  task automatic test_write_err();
    wr(2'd0, 2'd2, 4'd4, 3'd0, 4'd0, 1'b1);
    n_vec++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL werr_2400: got %0b want 1", wr_err); end
    n_vec++; if (armed !== 4'b1010) begin n_err++; $display("FAIL werr_armed: got %b want 1010", armed); end
    cyc();
    n_vec++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL werr_pulse: got %0b want 0", wr_err); end
    wr(2'd0, 2'd1, 4'd9, 3'd6, 4'd0, 1'b1);
    n_vec++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL werr_m1: got %0b want 1", wr_err); end
    wr(2'd0, 2'd2, 4'd3, 3'd5, 4'd9, 1'b1);
    n_vec++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL werr_2359: got %0b want 0", wr_err); end
    n_vec++; if (armed !== 4'b1011) begin n_err++; $display("FAIL werr_armed2: got %b want 1011", armed); end
    wr(2'd0, 2'd2, 4'd4, 3'd0, 4'd0, 1'b0);
    n_vec++; if (armed !== 4'b1011) begin n_err++; $display("FAIL werr_unchanged: got %b want 1011", armed); end
    tick(2'd2, 4'd3, 3'd5, 4'd9, 6'd0);
    n_vec++; if (ring !== 1'b1) begin n_err++; $display("FAIL werr_ring: got %0b want 1", ring); end
    n_vec++; if (active_id !== 2'd0) begin n_err++; $display("FAIL werr_id: got %0d want 0", active_id); end
  endtask

  task automatic test_disarm();
    wr(2'd3, 2'd0, 4'd6, 3'd0, 4'd0, 1'b0);
    n_vec++; if (ring !== 1'b1) begin n_err++; $display("FAIL dis_other: got %0b want 1", ring); end
    n_vec++; if (armed !== 4'b0011) begin n_err++; $display("FAIL dis_armed: got %b want 0011", armed); end
    wr(2'd0, 2'd2, 4'd3, 3'd5, 4'd9, 1'b0);
    n_vec++; if (ring !== 1'b0) begin n_err++; $display("FAIL dis_active: got %0b want 0", ring); end
    n_vec++; if (armed !== 4'b0010) begin n_err++; $display("FAIL dis_armed2: got %b want 0010", armed); end
  endtask

  task automatic test_write_trigger();
    cur_h1 = 2'd0; cur_h2 = 4'd6; cur_m1 = 3'd0; cur_m2 = 4'd0; cur_s = 6'd0;
    wr_sel = 2'd1; wr_h1 = 2'd0; wr_h2 = 4'd6; wr_m1 = 3'd0; wr_m2 = 4'd0; wr_arm = 1'b0;
    sec_tick = 1'b1; wr_en = 1'b1;
    cyc();
    sec_tick = 1'b0; wr_en = 1'b0;
    n_vec++; if (ring !== 1'b1) begin n_err++; $display("FAIL wt_ring: got %0b want 1", ring); end
    n_vec++; if (active_id !== 2'd1) begin n_err++; $display("FAIL wt_id: got %0d want 1", active_id); end
    n_vec++; if (armed !== 4'b0000) begin n_err++; $display("FAIL wt_armed: got %b want 0000", armed); end
    press_dismiss();
    wr(2'd3, 2'd0, 4'd6, 3'd0, 4'd0, 1'b1);
  endtask

`ifdef ALARM_TIMEOUT_EN
  task automatic test_timeout();
    tick(2'd0, 4'd6, 3'd0, 4'd0, 6'd0);
    tick(2'd0, 4'd6, 3'd0, 4'd0, 6'd1);
    tick(2'd0, 4'd6, 3'd0, 4'd0, 6'd2);
    n_vec++; if (ring !== 1'b1) begin n_err++; $display("FAIL tmo_still_ring: got %0b want 1", ring); end
    tick(2'd0, 4'd6, 3'd0, 4'd0, 6'd3);
    n_vec++; if (snoozing !== 1'b1) begin n_err++; $display("FAIL tmo_snoozing: got %0b want 1", snoozing); end
    n_vec++; if (snooze_cnt !== 2'd1) begin n_err++; $display("FAIL tmo_cnt: got %0d want 1", snooze_cnt); end
    press_dismiss();
  endtask
`endif

  task automatic test_async_reset();
    tick(2'd0, 4'd6, 3'd0, 4'd0, 6'd0);
    n_vec++; if (active_id !== 2'd3) begin n_err++; $display("FAIL ar_id: got %0d want 3", active_id); end
    press_snooze();
    tick(2'd0, 4'd6, 3'd0, 4'd0, 6'd1);
    n_vec++; if (snooze_left !== 3'd4) begin n_err++; $display("FAIL ar_left: got %0d want 4", snooze_left); end
    #2;
    rst = 1'b0;
    #1;
    n_vec++; if (ring !== 1'b0) begin n_err++; $display("FAIL ar_ring: got %0b want 0", ring); end
    n_vec++; if (snoozing !== 1'b0) begin n_err++; $display("FAIL ar_snoozing: got %0b want 0", snoozing); end
    n_vec++; if (snooze_left !== 3'd0) begin n_err++; $display("FAIL ar_snooze_left: got %0d want 0", snooze_left); end
    n_vec++; if (armed !== 4'b0000) begin n_err++; $display("FAIL ar_armed: got %b want 0000", armed); end
    #10;
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    rst = 1'b0; sec_tick = 1'b0; wr_en = 1'b0; wr_arm = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    cur_h1 = 2'd0; cur_h2 = 4'd0; cur_m1 = 3'd0; cur_m2 = 4'd0; cur_s = 6'd1;
    wr_sel = 2'd0; wr_h1 = 2'd0; wr_h2 = 4'd0; wr_m1 = 3'd0; wr_m2 = 4'd0;
    test_reset();
    test_trigger();
    test_priority();
    test_snooze();
    test_max_snooze();
    test_back_to_back();
    test_write_err();
    test_disarm();
    test_write_trigger();
`ifdef ALARM_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
